// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32 data memory with load/store formatting, faults and clear engine.
// Optional bounds check enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_lsu #(
  parameter int DEPTH_WORDS  = 1024,
  parameter bit CLR_ON_RESET = 1'b1,
  parameter     INIT_FILE    = ""
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic [2:0]  o_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   cnt_q;
  logic [AW-1:0]   cnt_d;
  logic            clr_we;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [31:0]     word;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic            f_mis;
  logic            f_ill;
  logic            f_oob;
  logic [2:0]      fault;
  logic [3:0]      mask;
  logic [31:0]     wd;
  logic [31:0]     ld_val;
  logic            accept;
  logic            st_we;

  assign idx  = i_addr[AW+1:2];
  assign lane = i_addr[1:0];
  assign word = mem[idx];
  assign bsel = 8'(word >> {lane, 3'b000});
  assign hsel = i_addr[1] ? word[31:16] : word[15:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign f_oob = |i_addr[31:AW+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_addr[31:AW+2];
  assign f_oob = 1'b0;
`endif

  // state and clear counter register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      if (CLR_ON_RESET) state_q <= S_CLEAR;
      else              state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: sweep every word with zero, then serve requests
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    o_ready = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (&cnt_q) state_d = S_IDLE;
      end
      S_IDLE: o_ready = 1'b1;
      default: ;
    endcase
  end

  // funct3 decode: faults, store lanes and load formatting
  always_comb begin
    f_mis  = 1'b0;
    f_ill  = 1'b0;
    mask   = 4'b0000;
    wd     = i_wdata;
    ld_val = '0;
    unique case (i_funct3)
      3'b000: begin
        mask   = 4'b0001 << lane;
        wd     = {4{i_wdata[7:0]}};
        ld_val = {{24{bsel[7]}}, bsel};
      end
      3'b001: begin
        f_mis  = i_addr[0];
        mask   = 4'b0011 << lane;
        wd     = {2{i_wdata[15:0]}};
        ld_val = {{16{hsel[15]}}, hsel};
      end
      3'b010: begin
        f_mis  = |lane;
        mask   = 4'b1111;
        ld_val = word;
      end
      3'b100: begin
        f_ill  = i_wren;
        ld_val = {24'd0, bsel};
      end
      3'b101: begin
        f_mis  = i_addr[0];
        f_ill  = i_wren;
        ld_val = {16'd0, hsel};
      end
      default: f_ill = 1'b1;
    endcase
  end

  assign fault  = {f_oob, f_ill, f_mis};
  assign accept = i_req & o_ready;
  assign st_we  = accept & i_wren & ~|fault & ~i_reset;

  // memory write port shared by clear engine and stores
  always_ff @(posedge i_clk) begin
    if (clr_we && !i_reset) begin
      mem[cnt_q] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  // response: ack pulse, result and fault held until next ack
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ack   <= 1'b0;
      o_rdata <= '0;
      o_fault <= '0;
    end else begin
      o_ack <= accept;
      if (accept) begin
        o_fault <= fault;
        o_rdata <= (i_wren || |fault) ? '0 : ld_val;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and random checks of dmem_lsu against a byte-array model.
// Bounds-fault checks compile in when DMEM_BOUNDS_CHECK_EN is defined.
module tb_dmem_lsu;

  localparam int DW = 16;
  localparam int NB = 4 * DW;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req;
  logic        i_wren;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_ready;
  logic        o_ack;
  logic [31:0] o_rdata;
  logic [2:0]  o_fault;

  int checks = 0;
  int errors = 0;

  logic [7:0] mb [NB];

  always #5 i_clk = ~i_clk;

  dmem_lsu #(
    .DEPTH_WORDS (DW),
    .CLR_ON_RESET(1'b1),
    .INIT_FILE   ("")
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (i_req),
    .i_wren  (i_wren),
    .i_funct3(i_funct3),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_ready (o_ready),
    .o_ack   (o_ack),
    .o_rdata (o_rdata),
    .o_fault (o_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [2:0] mfault(input logic w, input logic [2:0] f3,
                                        input logic [31:0] a);
    logic mis, ill, oob;
    mis = ((f3 == 3'd1 || f3 == 3'd5) && a % 2 != 0) ||
          (f3 == 3'd2 && a % 4 != 0);
    ill = (f3 == 3'd3 || f3 >= 3'd6) || (w && (f3 == 3'd4 || f3 == 3'd5));
`ifdef DMEM_BOUNDS_CHECK_EN
    oob = (a >= NB);
`else
    oob = 1'b0;
`endif
    return {oob, ill, mis};
  endfunction

  function automatic logic [31:0] mload(input logic [2:0] f3,
                                        input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (32'(mb[(a + i) % NB]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mstore(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
    int n;
    n = nbytes(f3);
    for (int i = 0; i < n; i++) mb[(a + i) % NB] = d[8*i +: 8];
  endtask

  task automatic mclear();
    for (int i = 0; i < NB; i++) mb[i] = 8'h00;
  endtask

  task automatic req(input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
    logic [2:0]  ef;
    logic [31:0] er;
    ef = mfault(w, f3, a);
    er = (w || ef != 3'd0) ? 32'd0 : mload(f3, a);
    if (w && ef == 3'd0) mstore(f3, a, d);
    i_req    = 1'b1;
    i_wren   = w;
    i_funct3 = f3;
    i_addr   = a;
    i_wdata  = d;
    @(negedge i_clk);
    i_req = 1'b0;
    chk({tag, ".ack"}, 32'(o_ack), 32'd1);
    chk({tag, ".fault"}, 32'(o_fault), 32'(ef));
    if (!w || ef != 3'd0) chk({tag, ".rdata"}, o_rdata, er);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      chk("idle.ack", 32'(o_ack), 32'd0);
    end
  endtask

  task automatic wait_clear(input string tag);
    int lows, acks;
    lows = 0;
    acks = 0;
    i_reset = 1'b0;
    while (!o_ready && lows < 40) begin
      lows++;
      @(negedge i_clk);
      if (o_ack) acks++;
    end
    i_req = 1'b0;
    chk({tag, ".ready_low"}, 32'(lows), 32'(DW));
    chk({tag, ".no_ack"}, 32'(acks), 32'd0);
    mclear();
  endtask

  initial begin
    logic [31:0] a, d, held;
    logic [2:0]  f3;
    logic        w;

    i_reset  = 1'b1;
    i_req    = 1'b0;
    i_wren   = 1'b0;
    i_funct3 = 3'd0;
    i_addr   = '0;
    i_wdata  = '0;
    mclear();
    repeat (2) @(negedge i_clk);
    chk("rst.ack", 32'(o_ack), 32'd0);
    chk("rst.rdata", o_rdata, 32'd0);
    chk("rst.fault", 32'(o_fault), 32'd0);
    chk("rst.ready", 32'(o_ready), 32'd0);

    i_req   = 1'b1;
    i_wren  = 1'b1;
    i_funct3 = 3'b010;
    i_addr  = 32'h0;
    i_wdata = 32'hFFFF_FFFF;
    wait_clear("clr0");

    req("lw0", 1'b0, 3'b010, 32'h00, 0);
    req("lw3c", 1'b0, 3'b010, 32'h3C, 0);
    req("lwr", 1'b0, 3'b010, 32'($urandom_range(0, 15)) * 4, 0);

    req("sw8", 1'b1, 3'b010, 32'h08, 32'hA1B2_C3D4);
    req("lbB", 1'b0, 3'b000, 32'h0B, 0);
    req("lbuB", 1'b0, 3'b100, 32'h0B, 0);
    req("lhuA", 1'b0, 3'b101, 32'h0A, 0);
    chk("lhuA.exact", o_rdata, 32'h0000_A1B2);

    req("sw4", 1'b1, 3'b010, 32'h04, 32'h1122_3344);
    req("sb5", 1'b1, 3'b000, 32'h05, 32'h0000_0055);
    req("lw4a", 1'b0, 3'b010, 32'h04, 0);
    chk("lw4a.exact", o_rdata, 32'h1122_5544);
    req("sh6", 1'b1, 3'b001, 32'h06, 32'h0000_BEEF);
    req("lw4b", 1'b0, 3'b010, 32'h04, 0);
    chk("lw4b.exact", o_rdata, 32'hBEEF_5544);

    req("lw2mis", 1'b0, 3'b010, 32'h02, 0);
    chk("lw2mis.exact", 32'(o_fault), 32'd1);
    req("sh3mis", 1'b1, 3'b001, 32'h03, 32'h0000_1234);
    req("lw4c", 1'b0, 3'b010, 32'h04, 0);
    req("sbu.ill", 1'b1, 3'b100, 32'h04, 32'h0000_0077);
    chk("sbu.exact", 32'(o_fault), 32'd2);
    req("lw4d", 1'b0, 3'b010, 32'h04, 0);

    d = $urandom;
    req("b2b.sw", 1'b1, 3'b010, 32'h20, d);
    req("b2b.lw", 1'b0, 3'b010, 32'h20, 0);
    chk("b2b.exact", o_rdata, d);
    held = o_rdata;
    idle(3);
    chk("hold.rdata", o_rdata, held);

`ifdef DMEM_BOUNDS_CHECK_EN
    req("lw.oob", 1'b0, 3'b010, 32'(NB), 0);
    chk("oob.exact", 32'(o_fault), 32'd4);
`endif

    for (int k = 0; k < 300; k++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                       : 3'($urandom_range(0, 2));
      if (!w && $urandom_range(0, 3) == 0) f3 = 3'($urandom_range(4, 5));
      a  = ($urandom_range(0, 7) == 0) ? $urandom
                                       : 32'($urandom_range(0, 2 * NB - 1));
      d  = $urandom;
      req("rnd", w, f3, a, d);
      if ($urandom_range(0, 7) == 0) idle(1);
    end

    req("pre.sw", 1'b1, 3'b010, 32'h3C, 32'hDEAD_BEEF);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (7) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    wait_clear("clr7");
    req("post.lw", 1'b0, 3'b010, 32'h3C, 0);

    req("ra.sw", 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D);
    i_req    = 1'b1;
    i_wren   = 1'b0;
    i_funct3 = 3'b010;
    i_addr   = 32'h10;
    @(negedge i_clk);
    chk("ra.ack1", 32'(o_ack), 32'd1);
    chk("ra.data1", o_rdata, 32'hCAFE_F00D);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("ra.ack0", 32'(o_ack), 32'd0);
    chk("ra.rdata0", o_rdata, 32'd0);
    chk("ra.fault0", 32'(o_fault), 32'd0);
    i_req = 1'b0;
    wait_clear("clr_ra");
    req("ra.lw", 1'b0, 3'b010, 32'h10, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
